// File: rtl/fft_stream_pkg.sv
// Shared types and defaults for the FFT output streamer.
package fft_stream_pkg;

  localparam int DATA_W_DEF   = 50;
  localparam int N_POINTS_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] bin_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // A bank takes writes only until its frame is complete.
  function automatic logic is_accepting(input bank_state_e st);
    return (st == EMPTY) || (st == FILLING);
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One ping-pong frame buffer: bin storage, write mask, duplicate detect
// and the EMPTY/FILLING/FULL/DRAINING life cycle of a single frame.
module fft_frame_bank
  import fft_stream_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = $clog2(N_POINTS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output bank_state_e       state_o,
  output logic              full_o,
  output logic              wr_done_o,
  output logic              dup_o
);

  logic [DATA_W-1:0]   mem_q [N_POINTS];
  logic [N_POINTS-1:0] mask_q, mask_d;
  logic [N_POINTS-1:0] wr_bit_s;
  logic                wr_done_s;
  bank_state_e         state_q, state_d;
  logic                dup_q, dup_d;

  // Decode the write index and detect the write that completes the frame.
  always_comb begin
    wr_bit_s           = '0;
    wr_bit_s[wr_idx_i] = 1'b1;
    wr_done_s          = wr_en_i && (&(mask_q | wr_bit_s));
  end

  // Next bank state, write mask and duplicate-write flag.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dup_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (wr_en_i) begin
          state_d = wr_done_s ? FULL : FILLING;
        end else begin
          state_d = EMPTY;
        end
      end
      FILLING: begin
        if (wr_done_s) begin
          state_d = FULL;
        end else begin
          state_d = FILLING;
        end
      end
      FULL: begin
        if (start_i) begin
          state_d = DRAINING;
        end else begin
          state_d = FULL;
        end
      end
      DRAINING: begin
        if (clr_i) begin
          state_d = EMPTY;
        end else begin
          state_d = DRAINING;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clr_i) begin
      mask_d = '0;
    end else if (wr_en_i) begin
      mask_d = mask_q | wr_bit_s;
      dup_d  = mask_q[wr_idx_i];
    end else begin
      mask_d = mask_q;
    end
  end

  // Bank state, mask and duplicate pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      mask_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
    end
  end

  // Bin storage; contents are only meaningful under a set mask bit, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign state_o   = state_q;
  assign full_o    = (state_q == FULL);
  assign wr_done_o = wr_done_s;
  assign dup_o     = dup_q;

endmodule

// File: rtl/fft_out_streamer_chk.sv
// Protocol and bank-ownership checks for the FFT output streamer.
module fft_out_streamer_chk
  import fft_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        wr_en_i,
  input  logic [1:0]        clr_i,
  input  bank_state_e       st0_i,
  input  bank_state_e       st1_i,
  input  logic              m_tvalid_i,
  input  logic              m_tready_i,
  input  logic [DATA_W-1:0] m_tdata_i,
  input  logic [IDX_W-1:0]  m_tuser_i,
  input  logic              m_tlast_i
);

  // A write never lands in a bank that is draining or being cleared.
  a_no_wr_drain0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en_i[0] && ((st0_i == DRAINING) || clr_i[0])));
  a_no_wr_drain1: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en_i[1] && ((st1_i == DRAINING) || clr_i[1])));

  // A stalled beat holds all its fields.
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_tvalid_i && !m_tready_i) |=> (m_tvalid_i && $stable(m_tdata_i) &&
                                     $stable(m_tuser_i) && $stable(m_tlast_i)));

endmodule

// File: rtl/fft_out_streamer.sv
// Collects FFT result bins (any index order) into ping-pong banks and
// streams each completed frame in index order as a registered AXI-S master.
module fft_out_streamer
  import fft_stream_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = $clog2(N_POINTS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  input  logic [IDX_W-1:0]  res_idx_i,
  output logic              res_ready_o,
  output logic              m_tvalid_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic [IDX_W-1:0]  m_tuser_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i,
  output logic              dup_err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;

  logic [1:0]        wr_en_s, start_s, clr_s, full_s, wr_done_s, dup_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [IDX_W-1:0]  nxt_idx_s;
  logic              accept_s, hs_s;
  bank_state_e       state_s [2];
  logic [DATA_W-1:0] rd_data_s [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .N_POINTS (N_POINTS),
      .DATA_W   (DATA_W),
      .IDX_W    (IDX_W)
    ) u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en_s[b]),
      .wr_idx_i  (res_idx_i),
      .wr_data_i (res_data_i),
      .start_i   (start_s[b]),
      .clr_i     (clr_s[b]),
      .rd_idx_i  (rd_idx_s),
      .rd_data_o (rd_data_s[b]),
      .state_o   (state_s[b]),
      .full_o    (full_s[b]),
      .wr_done_o (wr_done_s[b]),
      .dup_o     (dup_s[b])
    );
  end

  assign res_ready_o = is_accepting(state_s[wr_bank_q]);
  assign accept_s    = res_valid_i && res_ready_o;
  assign hs_s        = tvalid_q && m_tready_i;
  assign nxt_idx_s   = cnt_q + IDX_W'(1);

  // Route an accepted write to the fill bank; move on once its frame completes.
  always_comb begin
    wr_en_s[0] = accept_s && !wr_bank_q;
    wr_en_s[1] = accept_s && wr_bank_q;
    if (|(wr_en_s & wr_done_s)) begin
      wr_bank_d = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
  end

  // Output beat sequencing: start a full bank when idle, advance on handshake,
  // and on the tlast handshake release the bank and chain into the other one.
  always_comb begin
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_bank_q;
    start_s   = 2'b00;
    clr_s     = 2'b00;
    rd_idx_s  = '0;
    if (!tvalid_q) begin
      if (full_s[rd_bank_q]) begin
        start_s[rd_bank_q] = 1'b1;
        tvalid_d           = 1'b1;
        tdata_d            = rd_data_s[rd_bank_q];
        cnt_d              = '0;
        tlast_d            = 1'b0;
      end else begin
        tvalid_d = 1'b0;
      end
    end else if (hs_s && !tlast_q) begin
      rd_idx_s = nxt_idx_s;
      tdata_d  = rd_data_s[rd_bank_q];
      cnt_d    = nxt_idx_s;
      tlast_d  = (nxt_idx_s == LAST_IDX);
    end else if (hs_s) begin
      clr_s[rd_bank_q] = 1'b1;
      rd_bank_d        = ~rd_bank_q;
      if (full_s[~rd_bank_q]) begin
        start_s[~rd_bank_q] = 1'b1;
        tvalid_d            = 1'b1;
        tdata_d             = rd_data_s[~rd_bank_q];
        cnt_d               = '0;
        tlast_d             = 1'b0;
      end else begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
        cnt_d    = '0;
        tlast_d  = 1'b0;
      end
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Bank pointers, read counter and the registered output beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
    end
  end

  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o  = tdata_q;
  assign m_tuser_o  = cnt_q;
  assign m_tlast_o  = tlast_q;
  assign dup_err_o  = |dup_s;

  fft_out_streamer_chk #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (wr_en_s),
    .clr_i      (clr_s),
    .st0_i      (state_s[0]),
    .st1_i      (state_s[1]),
    .m_tvalid_i (tvalid_q),
    .m_tready_i (m_tready_i),
    .m_tdata_i  (tdata_q),
    .m_tuser_i  (cnt_q),
    .m_tlast_i  (tlast_q)
  );

endmodule

// File: tb/tb_fft_out_streamer.sv
// Scoreboard bench for fft_out_streamer: a frame model pushes the expected
// beats when a frame's last missing bin is written; the reader pops them.
module tb_fft_out_streamer;

  localparam int N  = 8;
  localparam int DW = 50;
  localparam int IW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          res_valid_i;
  logic [DW-1:0] res_data_i;
  logic [IW-1:0] res_idx_i;
  logic          res_ready_o;
  logic          m_tvalid_o;
  logic [DW-1:0] m_tdata_o;
  logic [IW-1:0] m_tuser_o;
  logic          m_tlast_o;
  logic          m_tready_i;
  logic          dup_err_o;

  int checks = 0;
  int errors = 0;

  beat_t         sb[$];
  logic [DW-1:0] fm_data [N];
  logic [N-1:0]  fm_mask;

  always #5 clk = ~clk;

  fft_out_streamer #(.N_POINTS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .res_valid_i (res_valid_i),
    .res_data_i  (res_data_i),
    .res_idx_i   (res_idx_i),
    .res_ready_o (res_ready_o),
    .m_tvalid_o  (m_tvalid_o),
    .m_tdata_o   (m_tdata_o),
    .m_tuser_o   (m_tuser_o),
    .m_tlast_o   (m_tlast_o),
    .m_tready_i  (m_tready_i),
    .dup_err_o   (dup_err_o)
  );

  // Drive one bin write (waiting for res_ready_o), update the frame model,
  // and return dup_err_o as seen in the cycle after the write.
  task automatic wr(input int idx, input logic [DW-1:0] d, output logic dup_seen);
    int    w;
    beat_t b;
    w = 0;
    while (res_ready_o !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (res_ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wr_ready_timeout: res_ready_o=%b required 1", res_ready_o);
    end
    res_valid_i = 1'b1;
    res_idx_i   = IW'(idx);
    res_data_i  = d;
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    dup_seen    = dup_err_o;
    fm_data[idx] = d;
    fm_mask[idx] = 1'b1;
    if (&fm_mask) begin
      for (int i = 0; i < N; i++) begin
        b.d = fm_data[i];
        b.u = IW'(i);
        b.l = (i == N - 1);
        sb.push_back(b);
      end
      fm_mask = '0;
    end
  endtask

  // Consume nbeats output beats against the scoreboard, optionally stalling
  // stall_cycles cycles on beat stall_beat; counts idle cycles mid-stream.
  task automatic consume(input int nbeats, input int stall_beat, input int stall_cycles,
                         output int bubbles);
    int    got, cyc, stalled;
    logic  started;
    beat_t exp;
    got = 0; cyc = 0; stalled = 0; started = 1'b0; bubbles = 0;
    while (got < nbeats && cyc < 400) begin
      if (m_tvalid_o === 1'b1) begin
        started = 1'b1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: tuser=%0d tdata=%h with empty scoreboard", m_tuser_o, m_tdata_o);
          m_tready_i = 1'b1;
          got++;
        end else if (got == stall_beat && stalled < stall_cycles) begin
          exp = sb[0];
          m_tready_i = 1'b0;
          stalled++;
          checks++;
          if (m_tdata_o !== exp.d || m_tuser_o !== exp.u || m_tlast_o !== exp.l) begin
            errors++;
            $display("FAIL hold_stable: got d=%h u=%0d l=%b required d=%h u=%0d l=%b",
                     m_tdata_o, m_tuser_o, m_tlast_o, exp.d, exp.u, exp.l);
          end
        end else begin
          exp = sb.pop_front();
          m_tready_i = 1'b1;
          checks++;
          if (m_tdata_o !== exp.d || m_tuser_o !== exp.u || m_tlast_o !== exp.l) begin
            errors++;
            $display("FAIL beat: got d=%h u=%0d l=%b required d=%h u=%0d l=%b",
                     m_tdata_o, m_tuser_o, m_tlast_o, exp.d, exp.u, exp.l);
          end
          got++;
        end
      end else begin
        m_tready_i = 1'b1;
        if (started) bubbles++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got < nbeats) begin
      checks++; errors++;
      $display("FAIL consume_timeout: got %0d beats required %0d", got, nbeats);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; res_valid_i = 1'b0; res_data_i = '0; res_idx_i = '0; m_tready_i = 1'b0;
    fm_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid_o, m_tlast_o, dup_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: tvalid/tlast/dup=%b required 000", {m_tvalid_o, m_tlast_o, dup_err_o});
    end
    checks++;
    if (m_tdata_o !== '0 || m_tuser_o !== '0) begin
      errors++;
      $display("FAIL reset_data: tdata=%h tuser=%0d required 0", m_tdata_o, m_tuser_o);
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: res_ready_o=%b required 1", res_ready_o);
    end
  endtask

  task automatic test_basic();
    logic d, dup_any;
    int   bub;
    m_tready_i = 1'b1;
    dup_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr(i, DW'(50'h10 + 50'(i)), d);
      dup_any |= d;
    end
    checks++;
    if (m_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: tvalid=%b required 0 in completing-write+1 cycle", m_tvalid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (m_tvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_first_beat: tvalid=%b required 1", m_tvalid_o);
    end
    consume(N, -1, 0, bub);
    checks++;
    if (bub !== 0) begin
      errors++;
      $display("FAIL basic_bubbles: %0d idle cycles required 0", bub);
    end
    checks++;
    if (dup_any !== 1'b0) begin
      errors++;
      $display("FAIL basic_dup: dup_err_o seen=%b required 0", dup_any);
    end
    checks++;
    if (m_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_after_tlast: tvalid=%b required 0", m_tvalid_o);
    end
  endtask

  task automatic test_bitrev();
    int   ord [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic d;
    int   bub;
    for (int i = 0; i < N; i++) wr(ord[i], DW'(100 + ord[i]), d);
    consume(N, -1, 0, bub);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL bitrev_leftover: %0d beats unconsumed required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic d;
    int   bub;
    for (int i = 0; i < N; i++) wr(i, DW'(100 + i), d);
    consume(N, 3, 5, bub);
    checks++;
    if (bub !== 0) begin
      errors++;
      $display("FAIL bp_bubbles: %0d idle cycles required 0", bub);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_tvalid_o !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL bp_extra_beat: tvalid=%b pending=%0d required 0/0", m_tvalid_o, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int bub;
    m_tready_i = 1'b1;
    fork
      begin
        logic d0;
        for (int i = 0; i < N; i++) wr(i, DW'(i), d0);
        for (int i = 0; i < N; i++) wr(i, DW'(50'h100 + 50'(i)), d0);
      end
      begin
        consume(2 * N, -1, 0, bub);
      end
    join
    checks++;
    if (bub !== 0) begin
      errors++;
      $display("FAIL b2b_bubbles: %0d idle cycles required 0", bub);
    end
  endtask

  task automatic test_both_full();
    logic  d;
    int    bub;
    beat_t exp;
    m_tready_i = 1'b0;
    for (int i = 0; i < N; i++) wr(i, DW'(50'h300 + 50'(i)), d);
    for (int i = 0; i < N; i++) wr(i, DW'(50'h400 + 50'(i)), d);
    checks++;
    if (res_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: res_ready_o=%b required 0", res_ready_o);
    end
    res_valid_i = 1'b1; res_idx_i = 3'd2; res_data_i = 50'hDEAD;
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    checks++;
    if (dup_err_o !== 1'b0 || res_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL dropped_write: dup=%b ready=%b required 0/0", dup_err_o, res_ready_o);
    end
    consume(N - 1, -1, 0, bub);
    checks++;
    if (res_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_tlast: res_ready_o=%b required 0", res_ready_o);
    end
    exp = sb.pop_front();
    m_tready_i = 1'b1;
    checks++;
    if (m_tvalid_o !== 1'b1 || m_tdata_o !== exp.d || m_tlast_o !== exp.l) begin
      errors++;
      $display("FAIL full_tlast_beat: v=%b d=%h l=%b required 1 %h %b", m_tvalid_o, m_tdata_o, m_tlast_o, exp.d, exp.l);
    end
    @(posedge clk); #1;
    checks++;
    if (res_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_tlast: res_ready_o=%b required 1", res_ready_o);
    end
    consume(N, -1, 0, bub);
    checks++;
    if (bub !== 0) begin
      errors++;
      $display("FAIL full_second_bubbles: %0d idle cycles required 0", bub);
    end
  endtask

  task automatic test_dup_and_reset();
    logic d;
    int   dup_cnt, bub, vcnt;
    m_tready_i = 1'b1;
    dup_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      wr(i, DW'(50'h500 + 50'(i)), d);
      if (d) dup_cnt++;
    end
    wr(3, 50'd5, d);
    if (d) dup_cnt++;
    wr(3, 50'd9, d);
    checks++;
    if (d !== 1'b1) begin
      errors++;
      $display("FAIL dup_pulse: dup_err_o=%b required 1 after second idx3 write", d);
    end
    if (d) dup_cnt++;
    for (int i = 4; i < N; i++) begin
      wr(i, DW'(50'h500 + 50'(i)), d);
      if (d) dup_cnt++;
    end
    checks++;
    if (dup_cnt !== 1) begin
      errors++;
      $display("FAIL dup_count: %0d pulses required 1", dup_cnt);
    end
    consume(4, -1, 0, bub);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (m_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tvalid=%b required 0", m_tvalid_o);
    end
    sb.delete();
    fm_mask = '0;
    #3;
    rst_ni = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_tvalid_o !== 1'b0) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin
      errors++;
      $display("FAIL post_reset_beats: %0d valid cycles required 0", vcnt);
    end
    for (int i = 0; i < N; i++) wr(i, DW'(50'h600 + 50'(i)), d);
    consume(N, -1, 0, bub);
    checks++;
    if (bub !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_frame: bubbles=%0d pending=%0d required 0/0", bub, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bitrev();
    test_backpressure();
    test_back_to_back();
    test_both_full();
    test_dup_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
